split_target_port: RTL and testbench
====================================

# split_target_port

Target-side serial-to-parallel port for the serial bus. It deserializes the address and write data from the bus, presents them as single-cycle parallel pulses to a split-capable target memory, and serializes the read data back onto the bus. It also relays split acknowledge, split request and split grant between the bus arbiter and the target. It sits directly upstream of the split-capable target.

## Interface
- ADDR_BITS, 16, serial address length and parallel address width
- DATA_BITS, 8, serial data length and parallel data width

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- bus_addr  in  1  serial address bit, LSB first
- bus_addr_valid  in  1  bus_addr is valid this cycle
- bus_mode  in  1  1 = write, 0 = read; sampled with the first address bit
- bus_wdata  in  1  serial write-data bit, LSB first
- bus_wdata_valid  in  1  bus_wdata is valid this cycle
- bus_rdata  out  1  serial read-data bit, LSB first
- bus_rdata_valid  out  1  bus_rdata is valid
- bus_ack  out  1  one-cycle transaction-complete pulse
- bus_split_ack  out  1  one-cycle "read deferred" pulse
- bus_split_req  out  1  request to re-acquire the bus
- bus_split_grant  in  1  arbiter grant for a split completion
- bus_ready  out  1  port can accept a new address
- tgt_addr  out  ADDR_BITS  parallel address
- tgt_addr_valid  out  1  one-cycle address pulse
- tgt_rw  out  1  captured bus_mode
- tgt_wdata  out  DATA_BITS  parallel write data
- tgt_wdata_valid  out  1  one-cycle write-data pulse
- tgt_rdata  in  DATA_BITS  read data from target
- tgt_rdata_valid  in  1  read data valid
- tgt_ack  in  1  target acknowledge
- tgt_split_ack  in  1  target deferred the read
- tgt_split_req  in  1  target requests bus for split completion
- tgt_split_grant  out  1  grant forwarded to target
- tgt_ready  in  1  target can accept

## Operation
- States: IDLE, ADDR, WDATA, WAIT_WACK, WAIT_RD, SPLIT, RDATA_TX.
- IDLE: on bus_addr_valid && tgt_ready: shift in bit 0, latch bus_mode, bit counter = 1, go to ADDR.
- ADDR: shift one bit per cycle while bus_addr_valid is high. A low bus_addr_valid pauses shifting; the counter holds. After bit ADDR_BITS-1 is shifted in: pulse tgt_addr_valid with tgt_addr and tgt_rw stable. Then go to WDATA on a write, WAIT_RD on a read.
- WDATA: shift while bus_wdata_valid is high, pauses allowed. After DATA_BITS bits: pulse tgt_wdata_valid, go to WAIT_WACK.
- WAIT_WACK: on tgt_ack, pulse bus_ack and go to IDLE.
- WAIT_RD:
  - tgt_split_ack → pulse bus_split_ack, go to SPLIT.
  - tgt_rdata_valid → latch tgt_rdata, go to RDATA_TX.
  - If both arrive in the same cycle, rdata takes priority.
- SPLIT:
  - bus_split_req = tgt_split_req, registered.
  - tgt_split_grant = bus_split_grant, combinational, only in SPLIT; 0 in all other states.
  - tgt_rdata_valid → latch the data, go to RDATA_TX.
- RDATA_TX: drive DATA_BITS bits LSB first on consecutive cycles with bus_rdata_valid high. bus_ack pulses the cycle after the last bit, then go to IDLE.
- tgt_ack during a read is ignored; rdata_valid completes the read. Any tgt_* pulse arriving in an unexpected state is ignored.
- Bus inputs arriving in states that do not expect them are ignored.
- bus_ready = (state == IDLE) && tgt_ready, combinational.

## Timing
- Reset: every output is 0, state = IDLE, shift registers and counters are 0. Assertion mid-transaction aborts immediately; no pulses are emitted afterwards.
- tgt_addr_valid is registered and asserts the cycle after the last address bit is sampled. Unpaused address latency: ADDR_BITS+1 cycles from the first bit.
- tgt_wdata_valid asserts the cycle after the last data bit.
- bus_split_ack and bus_ack are registered, one cycle after the causing tgt_* input.
- bus_rdata bit 0 appears the cycle after tgt_rdata_valid is sampled.
- The bit counter is $clog2(max(ADDR_BITS, DATA_BITS)+1) bits wide and is cleared on every state entry. No wrap-around.
- Back-to-back transactions: a new address may start the cycle after bus_ack.

## Structure
- Package bus_pkg holds: the state enum, and the default ADDR_BITS and DATA_BITS constants shared with the target and arbiter.
- One sub-module, serial_shifter: parameterized WIDTH, with load, shift-in and shift-out modes, LSB first. It is instantiated once for the address, once for write data, and once for read data.

## Test plan
- Write 0x0012 ← 0xA5, no pauses: tgt_addr_valid with addr 0x0012 and rw 1 at cycle 17. tgt_wdata 0xA5 pulses after 8 more bits. tgt_ack → bus_ack next cycle.
- Non-split read of 0x00FF, rdata 0x3C: bus_rdata sequence is 0,0,1,1,1,1,0,0. bus_ack follows the 8th bit.
- Split read of 0x0040:
  - tgt_split_ack → bus_split_ack.
  - tgt_split_req → bus_split_req.
  - bus_split_grant → tgt_split_grant in the same cycle.
  - rdata 0x81 is serialized; bus_ack follows.
- Address with bus_addr_valid low for 3 cycles after bit 7: the captured address is unchanged and tgt_addr_valid is delayed by exactly 3 cycles.
- tgt_split_ack and tgt_rdata_valid in the same cycle: no bus_split_ack. Data goes straight to RDATA_TX.
- rst_n asserted during the 4th read-data bit: all outputs are 0 immediately. The next write after reset completes normally.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared serial-bus definitions: port FSM states and default bus widths
// used by the target port, target memory and arbiter.
package bus_pkg;

   localparam int unsigned BUS_ADDR_BITS = 16;
   localparam int unsigned BUS_DATA_BITS = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_WDATA,
      ST_WAIT_WACK,
      ST_WAIT_RD,
      ST_SPLIT,
      ST_RDATA_TX
   } state_e;

endpackage : bus_pkg

// File: rtl/serial_shifter.sv
// LSB-first shift register with parallel load.
// Ports: load/load_data  - parallel load (wins over shift)
//        shift_en/ser_in - shift ser_in into the MSB, everything moves toward bit 0
//        data_q          - register contents; data_q[0] is the serial output bit
module serial_shifter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             shift_en,
   input  logic             ser_in,
   output logic [WIDTH-1:0] data_q
);

   logic [WIDTH-1:0] data_d;

   // Next value: load, shift, or hold
   always_comb begin
      data_d = data_q;
      if (load) begin
         data_d = load_data;
      end else if (shift_en) begin
         data_d = {ser_in, data_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

endmodule : serial_shifter

// File: rtl/split_target_port.sv
// Target-side serial/parallel bridge for the split-capable serial bus.
// Deserializes address and write data into single-cycle pulses toward the
// target, serializes read data back to the bus, and relays split ack/req/grant.
// Ports: bus_*  - serial bus side (bits LSB first)
//        tgt_*  - parallel target side
//        bus_ready, tgt_split_grant are combinational; all other outputs registered.
module split_target_port
   import bus_pkg::*;
#(
   parameter int unsigned ADDR_BITS = BUS_ADDR_BITS,
   parameter int unsigned DATA_BITS = BUS_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 bus_addr,
   input  logic                 bus_addr_valid,
   input  logic                 bus_mode,
   input  logic                 bus_wdata,
   input  logic                 bus_wdata_valid,
   output logic                 bus_rdata,
   output logic                 bus_rdata_valid,
   output logic                 bus_ack,
   output logic                 bus_split_ack,
   output logic                 bus_split_req,
   input  logic                 bus_split_grant,
   output logic                 bus_ready,
   output logic [ADDR_BITS-1:0] tgt_addr,
   output logic                 tgt_addr_valid,
   output logic                 tgt_rw,
   output logic [DATA_BITS-1:0] tgt_wdata,
   output logic                 tgt_wdata_valid,
   input  logic [DATA_BITS-1:0] tgt_rdata,
   input  logic                 tgt_rdata_valid,
   input  logic                 tgt_ack,
   input  logic                 tgt_split_ack,
   input  logic                 tgt_split_req,
   output logic                 tgt_split_grant,
   input  logic                 tgt_ready
);

   localparam int unsigned MAX_BITS = (ADDR_BITS > DATA_BITS) ? ADDR_BITS : DATA_BITS;
   localparam int unsigned CNT_W    = $clog2(MAX_BITS + 1);
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BITS - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rw_q, rw_d;
   logic             addr_vld_q, addr_vld_d;
   logic             wdata_vld_q, wdata_vld_d;
   logic             ack_q, ack_d;
   logic             split_ack_q, split_ack_d;
   logic             split_req_q, split_req_d;
   logic             rd_vld_q, rd_vld_d;
   logic             addr_shift, wdata_shift, rd_load, rd_shift;
   logic [DATA_BITS-1:0] rd_q;
   logic             unused_rd_hi;

   serial_shifter #(.WIDTH(ADDR_BITS)) u_addr_sh (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (1'b0),
      .load_data ({ADDR_BITS{1'b0}}),
      .shift_en  (addr_shift),
      .ser_in    (bus_addr),
      .data_q    (tgt_addr)
   );

   serial_shifter #(.WIDTH(DATA_BITS)) u_wdata_sh (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (1'b0),
      .load_data ({DATA_BITS{1'b0}}),
      .shift_en  (wdata_shift),
      .ser_in    (bus_wdata),
      .data_q    (tgt_wdata)
   );

   // Zero-fill on shift-out so the line idles low once the word is sent
   serial_shifter #(.WIDTH(DATA_BITS)) u_rdata_sh (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (rd_load),
      .load_data (tgt_rdata),
      .shift_en  (rd_shift),
      .ser_in    (1'b0),
      .data_q    (rd_q)
   );

   // Next-state and registered-output decode
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rw_d        = rw_q;
      addr_vld_d  = 1'b0;
      wdata_vld_d = 1'b0;
      ack_d       = 1'b0;
      split_ack_d = 1'b0;
      split_req_d = 1'b0;
      rd_vld_d    = 1'b0;
      addr_shift  = 1'b0;
      wdata_shift = 1'b0;
      rd_load     = 1'b0;
      rd_shift    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus_addr_valid && tgt_ready) begin
               addr_shift = 1'b1;
               rw_d       = bus_mode;
               cnt_d      = CNT_W'(1);
               state_d    = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (bus_addr_valid) begin
               addr_shift = 1'b1;
               if (cnt_q == ADDR_LAST) begin
                  cnt_d      = '0;
                  addr_vld_d = 1'b1;
                  state_d    = rw_q ? ST_WDATA : ST_WAIT_RD;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_WDATA: begin
            if (bus_wdata_valid) begin
               wdata_shift = 1'b1;
               if (cnt_q == DATA_LAST) begin
                  cnt_d       = '0;
                  wdata_vld_d = 1'b1;
                  state_d     = ST_WAIT_WACK;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_WAIT_WACK: begin
            if (tgt_ack) begin
               ack_d   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_WAIT_RD: begin
            // Read data beats a simultaneous split ack: no deferral is reported
            if (tgt_rdata_valid) begin
               rd_load  = 1'b1;
               rd_vld_d = 1'b1;
               cnt_d    = '0;
               state_d  = ST_RDATA_TX;
            end else if (tgt_split_ack) begin
               split_ack_d = 1'b1;
               cnt_d       = '0;
               state_d     = ST_SPLIT;
            end
         end
         ST_SPLIT: begin
            if (tgt_rdata_valid) begin
               rd_load  = 1'b1;
               rd_vld_d = 1'b1;
               cnt_d    = '0;
               state_d  = ST_RDATA_TX;
            end else begin
               split_req_d = tgt_split_req;
            end
         end
         ST_RDATA_TX: begin
            rd_shift = 1'b1;
            if (cnt_q == DATA_LAST) begin
               cnt_d   = '0;
               ack_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d    = cnt_q + CNT_W'(1);
               rd_vld_d = 1'b1;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         rw_q        <= 1'b0;
         addr_vld_q  <= 1'b0;
         wdata_vld_q <= 1'b0;
         ack_q       <= 1'b0;
         split_ack_q <= 1'b0;
         split_req_q <= 1'b0;
         rd_vld_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rw_q        <= rw_d;
         addr_vld_q  <= addr_vld_d;
         wdata_vld_q <= wdata_vld_d;
         ack_q       <= ack_d;
         split_ack_q <= split_ack_d;
         split_req_q <= split_req_d;
         rd_vld_q    <= rd_vld_d;
      end
   end

   assign bus_rdata       = rd_q[0];
   assign bus_rdata_valid = rd_vld_q;
   assign bus_ack         = ack_q;
   assign bus_split_ack   = split_ack_q;
   assign bus_split_req   = split_req_q;
   assign tgt_addr_valid  = addr_vld_q;
   assign tgt_rw          = rw_q;
   assign tgt_wdata_valid = wdata_vld_q;

   // Gated by rst_n so every output is low while reset is held
   assign bus_ready       = rst_n && (state_q == ST_IDLE) && tgt_ready;
   assign tgt_split_grant = (state_q == ST_SPLIT) && bus_split_grant;

   // Only bit 0 of the read shifter drives the bus
   assign unused_rd_hi = ^rd_q[DATA_BITS-1:1];

endmodule : split_target_port

// File: tb/tb_split_target_port.sv
// Directed + randomized bench for split_target_port with a transaction-level model.
module tb_split_target_port;

   localparam int AB = 16;
   localparam int DB = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          bus_addr = 1'b0, bus_addr_valid = 1'b0, bus_mode = 1'b0;
   logic          bus_wdata = 1'b0, bus_wdata_valid = 1'b0;
   logic          bus_rdata, bus_rdata_valid, bus_ack, bus_split_ack, bus_split_req;
   logic          bus_split_grant = 1'b0;
   logic          bus_ready;
   logic [AB-1:0] tgt_addr;
   logic          tgt_addr_valid, tgt_rw;
   logic [DB-1:0] tgt_wdata;
   logic          tgt_wdata_valid;
   logic [DB-1:0] tgt_rdata = '0;
   logic          tgt_rdata_valid = 1'b0, tgt_ack = 1'b0, tgt_split_ack = 1'b0;
   logic          tgt_split_req = 1'b0;
   logic          tgt_split_grant;
   logic          tgt_ready = 1'b1;

   int checks = 0;
   int errors = 0;

   split_target_port #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
      .clk(clk), .rst_n(rst_n),
      .bus_addr(bus_addr), .bus_addr_valid(bus_addr_valid), .bus_mode(bus_mode),
      .bus_wdata(bus_wdata), .bus_wdata_valid(bus_wdata_valid),
      .bus_rdata(bus_rdata), .bus_rdata_valid(bus_rdata_valid),
      .bus_ack(bus_ack), .bus_split_ack(bus_split_ack), .bus_split_req(bus_split_req),
      .bus_split_grant(bus_split_grant), .bus_ready(bus_ready),
      .tgt_addr(tgt_addr), .tgt_addr_valid(tgt_addr_valid), .tgt_rw(tgt_rw),
      .tgt_wdata(tgt_wdata), .tgt_wdata_valid(tgt_wdata_valid),
      .tgt_rdata(tgt_rdata), .tgt_rdata_valid(tgt_rdata_valid), .tgt_ack(tgt_ack),
      .tgt_split_ack(tgt_split_ack), .tgt_split_req(tgt_split_req),
      .tgt_split_grant(tgt_split_grant), .tgt_ready(tgt_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change just after the rising edge; outputs are sampled on the falling edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic look();
      @(negedge clk);
   endtask

   function automatic logic [63:0] all_outs();
      return {30'b0, bus_rdata, bus_rdata_valid, bus_ack, bus_split_ack, bus_split_req,
              bus_ready, tgt_addr, tgt_addr_valid, tgt_rw, tgt_wdata, tgt_wdata_valid,
              tgt_split_grant};
   endfunction

   task automatic clear_inputs();
      bus_addr_valid = 0; bus_addr = 0; bus_mode = 0;
      bus_wdata_valid = 0; bus_wdata = 0; bus_split_grant = 0;
      tgt_rdata_valid = 0; tgt_ack = 0; tgt_split_ack = 0; tgt_split_req = 0;
      tgt_ready = 1;
   endtask

   // Address phase; optional gap of pause_len cycles after bit pause_at
   task automatic send_addr(input logic [AB-1:0] a, input logic mode,
                            input int pause_at, input int pause_len);
      for (int i = 0; i < AB; i++) begin
         bus_addr_valid = 1; bus_addr = a[i];
         bus_mode = (i == 0) ? mode : ~mode;
         look();
         if (i == 0) chk("bus_ready_idle", bus_ready, 1);
         else        chk("addr_valid_early", tgt_addr_valid, 0);
         if (i == 1) chk("bus_ready_busy", bus_ready, 0);
         tick();
         if (i == pause_at) begin
            for (int p = 0; p < pause_len; p++) begin
               bus_addr_valid = 0; bus_addr = 1'($urandom);
               look();
               chk("addr_valid_paused", tgt_addr_valid, 0);
               tick();
            end
         end
      end
      bus_addr_valid = 0;
      look();
      chk("addr_valid_pulse", tgt_addr_valid, 1);
      chk("tgt_addr", tgt_addr, a);
      chk("tgt_rw", tgt_rw, mode);
      tick();
   endtask

   task automatic send_wdata(input logic [DB-1:0] d, input int pause_at, input int pause_len);
      for (int i = 0; i < DB; i++) begin
         bus_wdata_valid = 1; bus_wdata = d[i];
         look();
         if (i == 0) chk("addr_valid_single", tgt_addr_valid, 0);
         chk("wdata_valid_early", tgt_wdata_valid, 0);
         tick();
         if (i == pause_at) begin
            for (int p = 0; p < pause_len; p++) begin
               bus_wdata_valid = 0; bus_wdata = 1'($urandom);
               look();
               chk("wdata_valid_paused", tgt_wdata_valid, 0);
               tick();
            end
         end
      end
      bus_wdata_valid = 0;
      look();
      chk("wdata_valid_pulse", tgt_wdata_valid, 1);
      chk("tgt_wdata", tgt_wdata, d);
      tick();
   endtask

   // Wait, then ack; unexpected read-side pulses meanwhile must be ignored
   task automatic finish_write(input int wait_n);
      for (int w = 0; w < wait_n; w++) begin
         tgt_rdata_valid = 1'($urandom); tgt_split_ack = 1'($urandom);
         look();
         chk("wack_early", bus_ack, 0);
         chk("wack_no_rvalid", bus_rdata_valid, 0);
         tick();
      end
      tgt_rdata_valid = 0; tgt_split_ack = 0;
      look();
      chk("wack_wdata_single", tgt_wdata_valid, 0);
      chk("wack_no_split", bus_split_ack, 0);
      tgt_ack = 1;
      tick();
      tgt_ack = 0;
      look();
      chk("write_bus_ack", bus_ack, 1);
      tick();
   endtask

   task automatic do_read(input logic [DB-1:0] d, input logic split, input logic both,
                          input int wait_n, input int reset_at);
      logic prev_req;
      logic r, g;
      prev_req = 0;
      for (int w = 0; w < wait_n; w++) begin
         tgt_ack = 1'($urandom); tgt_split_req = 1'($urandom); bus_split_grant = 1'($urandom);
         look();
         chk("rd_wait_no_ack", bus_ack, 0);
         chk("rd_wait_no_grant", tgt_split_grant, 0);
         chk("rd_wait_no_req", bus_split_req, 0);
         tick();
      end
      tgt_ack = 0; tgt_split_req = 0; bus_split_grant = 0;
      if (split && !both) begin
         tgt_split_ack = 1;
         tick();
         tgt_split_ack = 0;
         look();
         chk("bus_split_ack", bus_split_ack, 1);
         chk("split_req_start", bus_split_req, 0);
         tick();
         for (int k = 0; k < 4; k++) begin
            r = 1'($urandom); g = 1'($urandom);
            tgt_split_req = r; bus_split_grant = g;
            look();
            chk("split_grant_pass", tgt_split_grant, g);
            if (k > 0) chk("split_req_reg", bus_split_req, prev_req);
            chk("split_ack_single", bus_split_ack, 0);
            tick();
            prev_req = r;
         end
         tgt_split_req = 0; bus_split_grant = 0;
         look();
         chk("split_req_reg_last", bus_split_req, prev_req);
      end
      tgt_rdata = d; tgt_rdata_valid = 1; tgt_split_ack = both;
      tick();
      tgt_rdata_valid = 0; tgt_split_ack = 0; tgt_rdata = DB'($urandom);
      for (int i = 0; i < DB; i++) begin
         tgt_ack = 1'($urandom); bus_split_grant = 1'($urandom);
         look();
         chk("rdata_valid", bus_rdata_valid, 1);
         chk("rdata_bit", bus_rdata, d[i]);
         chk("rdata_no_ack", bus_ack, 0);
         chk("rdata_no_grant", tgt_split_grant, 0);
         if (i == 0) chk("no_split_ack_on_data", bus_split_ack, 0);
         if (i == reset_at) begin
            rst_n = 0;
            #1;
            chk("reset_mid_outputs", all_outs(), 64'd0);
            tick(); tick();
            look();
            chk("reset_held_outputs", all_outs(), 64'd0);
            rst_n = 1;
            tick();
            clear_inputs();
            return;
         end
         tick();
      end
      tgt_ack = 0; bus_split_grant = 0;
      look();
      chk("read_bus_ack", bus_ack, 1);
      chk("read_valid_done", bus_rdata_valid, 0);
      tick();
   endtask

   initial begin
      logic [AB-1:0] a;
      logic [DB-1:0] d;
      logic          m;
      int            pa, pl;

      clear_inputs();
      rst_n = 0;
      tick(); tick();
      look();
      chk("reset_outputs", all_outs(), 64'd0);
      rst_n = 1;
      tick();
      look();
      chk("ready_after_reset", bus_ready, 1);
      tgt_ready = 0; bus_addr_valid = 1; bus_addr = 1;
      look();
      chk("ready_tgt_busy", bus_ready, 0);
      tick();
      clear_inputs();

      // Write 0x0012 <- 0xA5
      send_addr(16'h0012, 1'b1, -1, 0);
      send_wdata(8'hA5, -1, 0);
      finish_write(2);

      // Non-split read of 0x00FF returning 0x3C (back-to-back after bus_ack)
      send_addr(16'h00FF, 1'b0, -1, 0);
      do_read(8'h3C, 1'b0, 1'b0, 2, -1);

      // Split read of 0x0040 returning 0x81
      send_addr(16'h0040, 1'b0, -1, 0);
      do_read(8'h81, 1'b1, 1'b0, 1, -1);

      // Three-cycle address gap after bit 7
      send_addr(16'hBEEF, 1'b1, 7, 3);
      send_wdata(8'h5A, 3, 2);
      finish_write(0);

      // Split ack and read data in the same cycle
      send_addr(16'h1234, 1'b0, -1, 0);
      do_read(8'hC6, 1'b1, 1'b1, 0, -1);

      // Reset during the 4th read-data bit, then a normal write
      send_addr(16'h0F0F, 1'b0, -1, 0);
      do_read(8'h9B, 1'b0, 1'b0, 1, 3);
      send_addr(16'h7001, 1'b1, -1, 0);
      send_wdata(8'h3E, -1, 0);
      finish_write(1);

      for (int t = 0; t < 24; t++) begin
         a  = AB'($urandom);
         d  = DB'($urandom);
         m  = 1'($urandom);
         pa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, AB - 2)) : -1;
         pl = int'($urandom_range(1, 4));
         send_addr(a, m, pa, pl);
         if (m) begin
            pa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, DB - 2)) : -1;
            send_wdata(d, pa, pl);
            finish_write(int'($urandom_range(0, 4)));
         end else begin
            do_read(d, 1'($urandom), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 4)), -1);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_split_target_port
